lsu_ctrl: RTL and testbench

- Load/store sequencer between the multi-cycle CPU control and data memory.
- Accepts one load/store op at a time and checks alignment.
- Drives a word-aligned memory request with byte enables, and waits on the memory ack handshake.
- For loads, byte-aligns the returned word and configures the existing load-extension unit via its 3-bit control code, then registers the extended result and stalls the CPU until done.

---
 rtl/lsu_ctrl_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_pkg
// Description : Shared types and constants for the load/store sequencer.
//               The op encodings double as the load-extension unit's control
//               codes, so they must never be renumbered independently.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

    // Operation encodings. Load codes are also the extension-unit ctr codes.
    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b001,
        OP_LBU = 3'b010,
        OP_LH  = 3'b011,
        OP_LHU = 3'b100,
        OP_SW  = 3'b101,
        OP_SB  = 3'b110,
        OP_SH  = 3'b111
    } op_t;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        REQ   = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Byte-enable base patterns (shifted into the addressed lane)
    localparam logic [3:0] c_BE_BYTE = 4'b0001;
    localparam logic [3:0] c_BE_HALF = 4'b0011;
    localparam logic [3:0] c_BE_WORD = 4'b1111;

    // Loads occupy codes 000..100; everything above is a store.
    function automatic logic is_load(input op_t op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
    endfunction

endpackage : lsu_ctrl_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the load/store sequencer.
//               Produces byte enables, lane-replicated store data, the
//               misalignment flag, and the byte-aligned read word.
// Ports       : i_type       - latched operation
//               i_addr_lo    - latched byte address bits [1:0]
//               i_wdata      - latched right-justified store data
//               i_rdata      - memory read word
//               o_be         - byte enables
//               o_wdata      - replicated store data
//               o_misaligned - address is illegal for this access size
//               o_ext_a      - read word shifted right to lane 0
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  op_t         i_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic [31:0] o_ext_a
);

    always_comb begin
        o_be         = c_BE_WORD;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        case (i_type)
            OP_SB: begin
                o_be    = c_BE_BYTE << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            OP_SH: begin
                // Half lanes sit at byte 0 or byte 2
                o_be         = c_BE_HALF << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            OP_LH, OP_LHU: o_misaligned = i_addr_lo[0];
            OP_LW, OP_SW:  o_misaligned = |i_addr_lo;
            default:       ;
        endcase
    end

    // Shift the addressed byte/half down to bit 0 for the extension unit
    assign o_ext_a = i_rdata >> {i_addr_lo, 3'b000};

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store sequencer between CPU control and data memory.
//               Accepts one op at a time, checks alignment, issues a
//               word-aligned memory request, waits for ack (with timeout),
//               and registers the extended load result.
// Ports       : clk, rst_n                      - clock / async low reset
//               i_op_valid/type/addr/wdata      - CPU op request
//               o_busy, o_done, o_rdata         - CPU stall / completion / result
//               o_exc_adel/ades/bus             - exceptions, pulse with done
//               o_mem_req/we/addr/be/wdata      - memory request (registered)
//               i_mem_ack, i_mem_rdata          - memory response
//               o_ext_a, o_ext_ctr, i_ext_z     - external load-extension unit
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op_type,
    input  logic [31:0] i_op_addr,
    input  logic [31:0] i_op_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_exc_adel,
    output logic        o_exc_ades,
    output logic        o_exc_bus,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_ext_a,
    output logic [2:0]  o_ext_ctr,
    input  logic [31:0] i_ext_z
);

    // Last counter value before timeout; reached on the TIMEOUT-th unacked cycle
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    op_t              r_type;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misaligned;
    logic        w_is_load;

    assign w_is_load = is_load(r_type);

    lsu_align u_align (
        .i_type       (r_type),
        .i_addr_lo    (r_addr[1:0]),
        .i_wdata      (r_wdata),
        .i_rdata      (i_mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .o_ext_a      (o_ext_a)
    );

    // Load codes are the extension-unit codes; stores present pass-through
    assign o_ext_ctr = w_is_load ? 3'(r_type) : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_type      <= OP_LW;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rdata     <= '0;
            o_exc_adel  <= 1'b0;
            o_exc_ades  <= 1'b0;
            o_exc_bus   <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
        end else begin
            // Completion flags are single-cycle pulses
            o_done     <= 1'b0;
            o_exc_adel <= 1'b0;
            o_exc_ades <= 1'b0;
            o_exc_bus  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_op_valid) begin
                        r_type  <= op_t'(i_op_type);
                        r_addr  <= i_op_addr;
                        r_wdata <= i_op_wdata;
                        o_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end

                CHECK: begin
                    if (w_misaligned) begin
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_exc_adel <= w_is_load;
                        o_exc_ades <= !w_is_load;
                        r_state    <= ERR;
                    end else begin
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= !w_is_load;
                        o_mem_addr  <= {r_addr[31:2], 2'b00};
                        o_mem_be    <= w_be;
                        o_mem_wdata <= w_wdata;
                        r_cnt       <= '0;
                        r_state     <= REQ;
                    end
                end

                REQ: begin
                    // Ack takes priority over a coincident timeout
                    if (i_mem_ack) begin
                        if (w_is_load) begin
                            o_rdata <= i_ext_z;
                        end
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        r_state   <= RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_exc_bus <= 1'b1;
                        r_state   <= ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RESP:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : lsu_ctrl
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed self-checking bench for lsu_ctrl, including a
//               behavioural model of the external load-extension unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ext_a;
    logic [2:0]  ext_ctr;
    logic [31:0] ext_z;

    int n_assert = 0;
    int n_fail   = 0;
    int req_cycles;

    lsu_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_op_valid  (op_valid),
        .i_op_type   (op_type),
        .i_op_addr   (op_addr),
        .i_op_wdata  (op_wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_rdata     (rdata),
        .o_exc_adel  (exc_adel),
        .o_exc_ades  (exc_ades),
        .o_exc_bus   (exc_bus),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_be    (mem_be),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_ext_a     (ext_a),
        .o_ext_ctr   (ext_ctr),
        .i_ext_z     (ext_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load-extension unit: 001 sign byte, 010 zero byte, 011 sign half,
    // 100 zero half, anything else passes through.
    always_comb begin
        ext_z = ext_a;
        case (ext_ctr)
            3'b001:  ext_z = {{24{ext_a[7]}}, ext_a[7:0]};
            3'b010:  ext_z = {24'h0, ext_a[7:0]};
            3'b011:  ext_z = {{16{ext_a[15]}}, ext_a[15:0]};
            3'b100:  ext_z = {16'h0, ext_a[15:0]};
            default: ext_z = ext_a;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
        op_valid = 1'b1;
        op_type  = t;
        op_addr  = a;
        op_wdata = w;
    endtask

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_type   = 3'b000;
        op_addr   = '0;
        op_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_be", mem_be, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- lb at 0x1003, immediate ack ----------------
        issue(3'b001, 32'h0000_1003, 32'h0);
        tick();                                   // CHECK (T+1)
        op_valid = 1'b0;
        chk("lb_busy_chk", busy, 1);
        chk("lb_req_chk", mem_req, 0);
        tick();                                   // REQ (T+2)
        chk("lb_req", mem_req, 1);
        chk("lb_we", mem_we, 0);
        chk("lb_addr", mem_addr, 32'h0000_1000);
        chk("lb_be", mem_be, 4'hF);
        mem_rdata = 32'h80FF_1234;
        mem_ack   = 1'b1;
        #1;
        chk("lb_ext_a", ext_a, 32'h0000_0080);
        chk("lb_ext_ctr", ext_ctr, 3'b001);
        chk("lb_done_early", done, 0);
        tick();                                   // RESP (T+3)
        mem_ack = 1'b0;
        chk("lb_done", done, 1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_busy_done", busy, 0);
        chk("lb_req_off", mem_req, 0);
        chk("lb_noexc", {exc_adel, exc_ades, exc_bus}, 0);
        tick();
        chk("lb_done_pulse", done, 0);

        // ---------------- sh at 0x2002, ack on 3rd REQ cycle ----------------
        issue(3'b111, 32'h0000_2002, 32'h0000_ABCD);
        tick();
        op_valid = 1'b0;
        tick();                                   // REQ cycle 1
        for (int i = 0; i < 3; i++) begin
            chk("sh_req", mem_req, 1);
            chk("sh_we", mem_we, 1);
            chk("sh_be", mem_be, 4'hC);
            chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
            chk("sh_addr", mem_addr, 32'h0000_2000);
            chk("sh_done_wait", done, 0);
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("sh_done", done, 1);
        chk("sh_req_off", mem_req, 0);
        chk("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        tick();

        // ---------------- lw at 0x3001: load address error ----------------
        issue(3'b000, 32'h0000_3001, 32'h0);
        tick();                                   // CHECK
        op_valid = 1'b0;
        chk("adel_req_chk", mem_req, 0);
        chk("adel_done_early", done, 0);
        tick();                                   // ERR (T+2)
        chk("adel_done", done, 1);
        chk("adel_exc", {exc_adel, exc_ades, exc_bus}, 3'b100);
        chk("adel_req", mem_req, 0);
        chk("adel_rdata", rdata, 32'hFFFF_FF80);
        tick();
        chk("adel_pulse", {done, exc_adel}, 0);

        // ---------------- sh at 0x3001: store address error ----------------
        issue(3'b111, 32'h0000_3001, 32'h0000_1111);
        tick();
        op_valid = 1'b0;
        tick();
        chk("ades_done", done, 1);
        chk("ades_exc", {exc_adel, exc_ades, exc_bus}, 3'b010);
        chk("ades_req", mem_req, 0);
        tick();

        // ---------------- lhu at 0x4002, never acked: timeout ----------------
        issue(3'b100, 32'h0000_4002, 32'h0);
        tick();
        op_valid = 1'b0;
        tick();                                   // first REQ cycle
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", req_cycles, 16);
        chk("to_done", done, 1);
        chk("to_exc", {exc_adel, exc_ades, exc_bus}, 3'b001);
        chk("to_rdata", rdata, 32'hFFFF_FF80);
        tick();

        // follow-up lh at 0x4002 completes normally
        issue(3'b011, 32'h0000_4002, 32'h0);
        tick();
        op_valid = 1'b0;
        tick();
        chk("lh_req", mem_req, 1);
        mem_rdata = 32'h8001_0000;
        mem_ack   = 1'b1;
        #1;
        chk("lh_ext_a", ext_a, 32'h0000_8001);
        tick();
        mem_ack = 1'b0;
        chk("lh_done", done, 1);
        chk("lh_exc", {exc_adel, exc_ades, exc_bus}, 0);
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        tick();

        // ---------------- reset pulsed during REQ ----------------
        issue(3'b000, 32'h0000_6000, 32'h0);
        tick();
        op_valid = 1'b0;
        tick();
        chk("rr_req_pre", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_req_async", mem_req, 0);
        chk("rr_busy_async", busy, 0);
        chk("rr_done_async", done, 0);
        tick();
        rst_n     = 1'b1;
        mem_rdata = 32'h1234_5678;
        mem_ack   = 1'b1;                         // stray ack while idle
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_no_done", done, 0);
        end
        mem_ack = 1'b0;
        issue(3'b000, 32'h0000_6000, 32'h0);
        tick();
        op_valid = 1'b0;
        tick();
        chk("rr2_addr", mem_addr, 32'h0000_6000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rr2_done", done, 1);
        chk("rr2_rdata", rdata, 32'h1234_5678);
        tick();

        // ---------------- lbu at 0x5000 with op_valid held high ----------------
        issue(3'b010, 32'h0000_5000, 32'h0);
        mem_rdata = 32'h0000_00F0;
        tick();                                   // CHECK
        chk("lbu_busy", busy, 1);
        tick();                                   // REQ, op_valid still high
        chk("lbu_req", mem_req, 1);
        chk("lbu_ext_ctr", ext_ctr, 3'b010);
        mem_ack = 1'b1;
        tick();                                   // RESP
        mem_ack  = 1'b0;
        op_valid = 1'b0;
        chk("lbu_done", done, 1);
        chk("lbu_rdata", rdata, 32'h0000_00F0);
        mem_ack = 1'b1;                           // stray ack in IDLE
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lbu_idle_done", done, 0);
            chk("lbu_idle_req", mem_req, 0);
            chk("lbu_idle_busy", busy, 0);
        end
        mem_ack = 1'b0;
        chk("lbu_rdata_hold", rdata, 32'h0000_00F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_lsu_ctrl
`default_nettype wire
